alu_op_sequencer: RTL

- Drives the regfile32x32 / multiplaxer2x1 / alu32 datapath from a stream of operation requests: register reads, operand select, ALU execution and regfile writeback.
- Replaces the hand-stepped stimulus sequencing currently used to exercise that datapath.
- First stage of the multicycle MIPS execute path.
- Requests arrive on a valid/ready handshake.
- Each accepted request completes in 4 cycles with a one-cycle done pulse.

---
 rtl/alu_op_sequencer_if.sv | 52 +++++
 rtl/alu_op_sequencer.sv | 95 +++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request handshake, regfile/ALU datapath buses and status outputs of the ALU op sequencer.
interface alu_op_sequencer_if #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned IW   = 16,
    parameter int unsigned CNTW = 16
);
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_rs;
    logic [AW-1:0]   req_rt;
    logic [AW-1:0]   req_rd;
    logic [IW-1:0]   req_imm;
    logic            req_use_imm;
    logic [3:0]      req_ctrl;

    logic [AW-1:0]   rf_raddr1;
    logic [AW-1:0]   rf_raddr2;
    logic [DW-1:0]   rf_rdata1;
    logic [DW-1:0]   rf_rdata2;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            rf_we;

    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [3:0]      alu_ctrl;
    logic [DW-1:0]   alu_result;
    logic            alu_ovf;

    logic            done;
    logic [DW-1:0]   done_result;
    logic            done_ovf;
    logic [CNTW-1:0] op_count;
    logic [7:0]      ovf_count;

    modport master (
        input  req_valid, req_rs, req_rt, req_rd, req_imm, req_use_imm, req_ctrl,
        input  rf_rdata1, rf_rdata2, alu_result, alu_ovf,
        output req_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_we,
        output alu_a, alu_b, alu_ctrl,
        output done, done_result, done_ovf, op_count, ovf_count
    );

    modport slave (
        output req_valid, req_rs, req_rt, req_rd, req_imm, req_use_imm, req_ctrl,
        output rf_rdata1, rf_rdata2, alu_result, alu_ovf,
        input  req_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_we,
        input  alu_a, alu_b, alu_ctrl,
        input  done, done_result, done_ovf, op_count, ovf_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Four-cycle IDLE/READ/EXEC/WRITE sequencer driving the regfile, operand mux and ALU
// for one accepted request at a time.
module alu_op_sequencer #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned IW   = 16,
    parameter int unsigned CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] rd_q;
    logic [3:0]    ctrl_q;
    logic          use_imm_q;
    logic [DW-1:0] imm_ext_q;

    logic [DW-1:0] imm_ext;
    assign imm_ext = {{(DW-IW){bus.req_imm[IW-1]}}, bus.req_imm};

    // Each state's outputs are loaded on the edge that enters it, so they are valid for the whole state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            rd_q            <= '0;
            ctrl_q          <= '0;
            use_imm_q       <= 1'b0;
            imm_ext_q       <= '0;
            bus.req_ready   <= 1'b1;
            bus.rf_raddr1   <= '0;
            bus.rf_raddr2   <= '0;
            bus.rf_waddr    <= '0;
            bus.rf_wdata    <= '0;
            bus.rf_we       <= 1'b0;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_ctrl    <= '0;
            bus.done        <= 1'b0;
            bus.done_result <= '0;
            bus.done_ovf    <= 1'b0;
            bus.op_count    <= '0;
            bus.ovf_count   <= '0;
        end else begin
            bus.rf_we <= 1'b0;
            bus.done  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        bus.rf_raddr1 <= bus.req_rs;
                        bus.rf_raddr2 <= bus.req_rt;
                        rd_q          <= bus.req_rd;
                        ctrl_q        <= bus.req_ctrl;
                        use_imm_q     <= bus.req_use_imm;
                        imm_ext_q     <= imm_ext;
                        bus.req_ready <= 1'b0;
                        state         <= S_READ;
                    end
                end
                S_READ: begin
                    bus.alu_a    <= bus.rf_rdata1;
                    bus.alu_b    <= use_imm_q ? imm_ext_q : bus.rf_rdata2;
                    bus.alu_ctrl <= ctrl_q;
                    state        <= S_EXEC;
                end
                S_EXEC: begin
                    // Writes to $zero and overflowed results never reach the regfile.
                    bus.rf_waddr    <= rd_q;
                    bus.rf_wdata    <= bus.alu_result;
                    bus.rf_we       <= (rd_q != AW'(0)) && !bus.alu_ovf;
                    bus.done        <= 1'b1;
                    bus.done_result <= bus.alu_result;
                    bus.done_ovf    <= bus.alu_ovf;
                    bus.op_count    <= bus.op_count + CNTW'(1);
                    if (bus.alu_ovf && (bus.ovf_count != 8'hFF)) begin
                        bus.ovf_count <= bus.ovf_count + 8'd1;
                    end
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    bus.req_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
